// File: rtl/dispatch_group_n_if.sv
// Dispatch-group bundle: instruction-queue side, RS occupancy inputs and per-lane dispatch outputs.
// The front end drives the master side; the dispatch unit attaches to the slave side.
interface dispatch_group_n_if #(
    parameter int DISPATCH_WIDTH = 2,
    parameter int RS_DEPTH       = 4,
    parameter int REG_W          = 5
);
    localparam int W     = DISPATCH_WIDTH;
    localparam int TAG_W = 1 + $clog2(RS_DEPTH);
    localparam int PC_W  = $clog2(W + 1);

    logic                 flush;
    logic [32*W-1:0]      instr_in;
    logic [W-1:0]         instr_valid;
    logic                 instr_queue_empty;
    logic [PC_W-1:0]      pop_count;
    logic [RS_DEPTH-1:0]  add_rs_busy;
    logic [RS_DEPTH-1:0]  mul_rs_busy;
    logic [W-1:0]         disp_valid;
    logic [TAG_W*W-1:0]   disp_tag;
    logic [REG_W*W-1:0]   disp_rs1;
    logic [REG_W*W-1:0]   disp_rs2;
    logic [REG_W*W-1:0]   disp_rd;
    logic [W-1:0]         src1_fwd;
    logic [W-1:0]         src2_fwd;
    logic [TAG_W*W-1:0]   src1_ftag;
    logic [TAG_W*W-1:0]   src2_ftag;
    logic                 done;

    modport master (
        output flush, instr_in, instr_valid, instr_queue_empty, add_rs_busy, mul_rs_busy,
        input  pop_count, disp_valid, disp_tag, disp_rs1, disp_rs2, disp_rd,
               src1_fwd, src2_fwd, src1_ftag, src2_ftag, done
    );

    modport slave (
        input  flush, instr_in, instr_valid, instr_queue_empty, add_rs_busy, mul_rs_busy,
        output pop_count, disp_valid, disp_tag, disp_rs1, disp_rs2, disp_rd,
               src1_fwd, src2_fwd, src1_ftag, src2_ftag, done
    );
endinterface

// File: rtl/dispatch_group_n.sv
// In-order N-wide dispatch into adder/multiplier reservation stations with intra-group RAW
// forwarding tags and an end-of-program drain/done FSM.
module dispatch_group_n #(
    parameter int DISPATCH_WIDTH = 2,
    parameter int RS_DEPTH       = 4,
    parameter int REG_W          = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    dispatch_group_n_if.slave dif
);
    localparam int W     = DISPATCH_WIDTH;
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int TAG_W = 1 + IDX_W;
    localparam int PC_W  = $clog2(W + 1);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_e;

    state_e state_q, state_d;
    logic   done_q, done_d;

    logic [W-1:0][31:0]      instr;
    logic [W-1:0]            is_add, is_mul;
    logic [W-1:0][REG_W-1:0] rs1, rs2, rd;

    logic [RS_DEPTH-1:0] add_resv_q, add_resv_d, mul_resv_q, mul_resv_d;
    logic [RS_DEPTH-1:0] add_taken, mul_taken;
    logic [W-1:0]            grant;
    logic [W-1:0][TAG_W-1:0] tag_c;
    logic [PC_W-1:0]         pop_c;
    logic                    stop, found;
    logic [IDX_W-1:0]        slot;

    logic [W-1:0]            fwd1_c, fwd2_c;
    logic [W-1:0][TAG_W-1:0] ftag1_c, ftag2_c;

    logic [W-1:0]            valid_q, fwd1_q, fwd2_q;
    logic [W-1:0][TAG_W-1:0] tag_q, ftag1_q, ftag2_q;
    logic [W-1:0][REG_W-1:0] rs1_q, rs2_q, rd_q;

    assign instr = dif.instr_in;

    always_comb begin : decode
        for (int unsigned i = 0; i < W; i++) begin
            is_add[i] = (instr[i][6:0] == 7'b0110011) && (instr[i][14:12] == 3'b000)
                        && (instr[i][31:25] == 7'b0000000);
            is_mul[i] = (instr[i][6:0] == 7'b0110011) && (instr[i][14:12] == 3'b000)
                        && (instr[i][31:25] == 7'b0000001);
            rs1[i]    = REG_W'(instr[i][19:15]);
            rs2[i]    = REG_W'(instr[i][24:20]);
            rd[i]     = REG_W'(instr[i][11:7]);
        end
    end

    // Slots granted last cycle stay reserved until the RS busy vector reflects them.
    always_comb begin : allocate
        add_taken  = dif.add_rs_busy | add_resv_q;
        mul_taken  = dif.mul_rs_busy | mul_resv_q;
        add_resv_d = '0;
        mul_resv_d = '0;
        grant      = '0;
        tag_c      = '0;
        pop_c      = '0;
        stop       = 1'b0;
        found      = 1'b0;
        slot       = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (!stop) begin
                if (!dif.instr_valid[i]) begin
                    stop = 1'b1;
                end else if (is_add[i] || is_mul[i]) begin
                    found = 1'b0;
                    slot  = '0;
                    for (int unsigned k = 0; k < RS_DEPTH; k++) begin
                        if (!found && !(is_mul[i] ? mul_taken[k] : add_taken[k])) begin
                            found = 1'b1;
                            slot  = IDX_W'(k);
                        end
                    end
                    if (!found) begin
                        stop = 1'b1;
                    end else begin
                        grant[i] = 1'b1;
                        tag_c[i] = {is_mul[i], slot};
                        pop_c    = pop_c + PC_W'(1);
                        if (is_mul[i]) begin
                            mul_taken[slot]  = 1'b1;
                            mul_resv_d[slot] = 1'b1;
                        end else begin
                            add_taken[slot]  = 1'b1;
                            add_resv_d[slot] = 1'b1;
                        end
                    end
                end else begin
                    pop_c = pop_c + PC_W'(1);
                end
            end
        end
        if (dif.flush) begin
            pop_c      = '0;
            add_resv_d = '0;
            mul_resv_d = '0;
        end
    end

    // Later matches overwrite earlier ones so the youngest older producer wins.
    always_comb begin : forward
        fwd1_c  = '0;
        fwd2_c  = '0;
        ftag1_c = '0;
        ftag2_c = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (grant[i]) begin
                for (int unsigned j = 0; j < i; j++) begin
                    if (grant[j] && (rd[j] != '0)) begin
                        if (rd[j] == rs1[i]) begin
                            fwd1_c[i]  = 1'b1;
                            ftag1_c[i] = tag_c[j];
                        end
                        if (rd[j] == rs2[i]) begin
                            fwd2_c[i]  = 1'b1;
                            ftag2_c[i] = tag_c[j];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : dispatch_regs
        if (!rst_n) begin
            valid_q    <= '0;
            tag_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            fwd1_q     <= '0;
            fwd2_q     <= '0;
            ftag1_q    <= '0;
            ftag2_q    <= '0;
            add_resv_q <= '0;
            mul_resv_q <= '0;
        end else if (dif.flush) begin
            valid_q    <= '0;
            tag_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            fwd1_q     <= '0;
            fwd2_q     <= '0;
            ftag1_q    <= '0;
            ftag2_q    <= '0;
            add_resv_q <= '0;
            mul_resv_q <= '0;
        end else begin
            valid_q    <= grant;
            fwd1_q     <= fwd1_c;
            fwd2_q     <= fwd2_c;
            ftag1_q    <= ftag1_c;
            ftag2_q    <= ftag2_c;
            add_resv_q <= add_resv_d;
            mul_resv_q <= mul_resv_d;
            for (int unsigned i = 0; i < W; i++) begin
                tag_q[i] <= grant[i] ? tag_c[i] : '0;
                rs1_q[i] <= grant[i] ? rs1[i]   : '0;
                rs2_q[i] <= grant[i] ? rs2[i]   : '0;
                rd_q[i]  <= grant[i] ? rd[i]    : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q <= S_RUN;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_RUN:   if (dif.instr_queue_empty && (dif.instr_valid == '0)) state_d = S_DRAIN;
            S_DRAIN: begin
                if (dif.instr_valid != '0) begin
                    state_d = S_RUN;
                end else if ((dif.add_rs_busy == '0) && (dif.mul_rs_busy == '0) &&
                             (add_resv_q == '0) && (mul_resv_q == '0) && (valid_q == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_RUN;
        endcase
        // Flush restarts the drain tracking but never revokes a completed program.
        if (dif.flush && (state_q != S_DONE)) state_d = S_RUN;
    end

    always_comb begin : outputs
        done_d = (state_q == S_DONE);
    end

    assign dif.pop_count  = pop_c;
    assign dif.disp_valid = valid_q;
    assign dif.disp_tag   = tag_q;
    assign dif.disp_rs1   = rs1_q;
    assign dif.disp_rs2   = rs2_q;
    assign dif.disp_rd    = rd_q;
    assign dif.src1_fwd   = fwd1_q;
    assign dif.src2_fwd   = fwd2_q;
    assign dif.src1_ftag  = ftag1_q;
    assign dif.src2_ftag  = ftag2_q;
    assign dif.done       = done_q;
endmodule
